// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan driver: FSM states, pixel bit
// positions inside a frame-buffer word, and the default panel geometry.
package hub75_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } state_e;

   localparam int PIX_R0 = 5;
   localparam int PIX_G0 = 4;
   localparam int PIX_B0 = 3;
   localparam int PIX_R1 = 2;
   localparam int PIX_G1 = 1;
   localparam int PIX_B1 = 0;

   localparam int DEF_COLS   = 64;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_COL_W  = 6;
   localparam int DEF_OE_ON  = 256;

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Frame-buffer read port plus HUB75 panel pins. The scan driver is the master:
// it issues reads and drives the panel. The frame buffer and panel form the slave side.
interface hub75_scan_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int COL_W  = 6
);
   logic                      fb_rd_en;
   logic [ADDR_W+COL_W-1:0]   fb_addr;
   logic [5:0]                fb_rdata;
   logic                      r0, g0, b0, r1, g1, b1;
   logic [ADDR_W-1:0]         addr;
   logic                      clk_out;
   logic                      latch;
   logic                      oe;
   logic                      frame_done;

   modport master (
      output fb_rd_en, fb_addr,
      input  fb_rdata,
      output r0, g0, b0, r1, g1, b1, addr, clk_out, latch, oe, frame_done
   );

   modport slave (
      input  fb_rd_en, fb_addr,
      output fb_rdata,
      input  r0, g0, b0, r1, g1, b1, addr, clk_out, latch, oe, frame_done
   );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/32-scan driver: per row pair, shifts COLS words from the frame buffer, blanks, latches, then lights for OE_ON cycles.
// All pins are registered; read data is taken the cycle after the strobe, so data leads each clk_out rise by one cycle.
module hub75_scan_ctrl
   import hub75_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int COL_W  = DEF_COL_W,
   parameter int OE_ON  = DEF_OE_ON
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   hub75_scan_ctrl_if.master bus
);

   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = {ADDR_W{1'b1}};
   localparam logic [15:0]       ON_LOAD  = 16'(OE_ON - 1);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       row_q, row_d, row_inc;
   logic [COL_W-1:0]        col_q, col_d, col_inc;
   logic                    phase_q, phase_d;
   logic [15:0]             timer_q, timer_d;
   logic                    rd_en_q, rd_en_d;
   logic [ADDR_W+COL_W-1:0] fb_addr_q, fb_addr_d;
   logic [5:0]              rgb_q, rgb_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    clk_out_q, clk_out_d;
   logic                    latch_q, latch_d;
   logic                    oe_q, oe_d;
   logic                    done_q, done_d;

   assign row_inc = row_q + 1'b1;
   assign col_inc = col_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         col_q     <= '0;
         phase_q   <= 1'b0;
         timer_q   <= '0;
         rd_en_q   <= 1'b0;
         fb_addr_q <= '0;
         rgb_q     <= '0;
         addr_q    <= '0;
         clk_out_q <= 1'b0;
         latch_q   <= 1'b0;
         oe_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         phase_q   <= phase_d;
         timer_q   <= timer_d;
         rd_en_q   <= rd_en_d;
         fb_addr_q <= fb_addr_d;
         rgb_q     <= rgb_d;
         addr_q    <= addr_d;
         clk_out_q <= clk_out_d;
         latch_q   <= latch_d;
         oe_q      <= oe_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      phase_d   = phase_q;
      timer_d   = timer_q;
      rd_en_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      rgb_d     = rgb_q;
      addr_d    = addr_q;
      clk_out_d = clk_out_q;
      latch_d   = 1'b0;
      oe_d      = oe_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            oe_d      = 1'b1;
            clk_out_d = 1'b0;
            if (enable) begin
               rd_en_d   = 1'b1;
               fb_addr_d = {row_q, {COL_W{1'b0}}};
               col_d     = '0;
               phase_d   = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         // oe is left alone here so the previous row stays lit during the shift
         ST_SHIFT: begin
            if (!phase_q) begin
               rgb_d     = bus.fb_rdata;
               clk_out_d = 1'b0;
               phase_d   = 1'b1;
            end else begin
               clk_out_d = 1'b1;
               if (col_q != COL_LAST) begin
                  rd_en_d   = 1'b1;
                  fb_addr_d = {row_q, col_inc};
                  col_d     = col_inc;
                  phase_d   = 1'b0;
               end else begin
                  state_d = ST_BLANK;
               end
            end
         end
         ST_BLANK: begin
            oe_d      = 1'b1;
            clk_out_d = 1'b0;
            state_d   = ST_LATCH;
         end
         ST_LATCH: begin
            latch_d = 1'b1;
            addr_d  = row_q;
            done_d  = (row_q == ROW_LAST);
            timer_d = ON_LOAD;
            state_d = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            oe_d = 1'b0;
            if (timer_q == 16'd0) begin
               row_d = row_inc;
               if (enable) begin
                  rd_en_d   = 1'b1;
                  fb_addr_d = {row_inc, {COL_W{1'b0}}};
                  col_d     = '0;
                  phase_d   = 1'b0;
                  state_d   = ST_SHIFT;
               end else begin
                  oe_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.fb_rd_en   = rd_en_q;
   assign bus.fb_addr    = fb_addr_q;
   assign bus.r0         = rgb_q[PIX_R0];
   assign bus.g0         = rgb_q[PIX_G0];
   assign bus.b0         = rgb_q[PIX_B0];
   assign bus.r1         = rgb_q[PIX_R1];
   assign bus.g1         = rgb_q[PIX_G1];
   assign bus.b1         = rgb_q[PIX_B1];
   assign bus.addr       = addr_q;
   assign bus.clk_out    = clk_out_q;
   assign bus.latch      = latch_q;
   assign bus.oe         = oe_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: random frame-buffer contents, a row-level panel model
// that tracks which row should be shifted next, plus a second instance with OE_ON=1.
module tb_hub75_scan_ctrl;

   localparam int COLS   = 64;
   localparam int ADDR_W = 5;
   localparam int COL_W  = 6;
   localparam int OE_ON  = 256;
   localparam int ROWS   = 1 << ADDR_W;
   localparam int PERIOD = 2 * COLS + 2 + OE_ON;

   logic clk;
   logic rst_n, enable;
   logic rst1_n, en1;

   logic [5:0] mem [0:(1<<(ADDR_W+COL_W))-1];

   int n_chk = 0;
   int n_err = 0;

   // panel model state, advanced only by the monitor process
   logic [ADDR_W-1:0] exp_row;
   int rise_cnt, cyc_since, oe_hi, fd_cnt;
   logic dirty, prev_clk;
   logic [ADDR_W-1:0] prev_addr;

   hub75_scan_ctrl_if #(.ADDR_W(ADDR_W), .COL_W(COL_W)) bus ();
   hub75_scan_ctrl_if #(.ADDR_W(ADDR_W), .COL_W(COL_W)) bus1 ();

   hub75_scan_ctrl #(.COLS(COLS), .ADDR_W(ADDR_W), .COL_W(COL_W), .OE_ON(OE_ON)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus)
   );

   hub75_scan_ctrl #(.COLS(COLS), .ADDR_W(ADDR_W), .COL_W(COL_W), .OE_ON(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .enable(en1), .bus(bus1)
   );

   // frame buffer: word for the strobed address is present while the strobe is high
   assign bus.fb_rdata  = bus.fb_rd_en  ? mem[bus.fb_addr]  : 6'h00;
   assign bus1.fb_rdata = bus1.fb_rd_en ? mem[bus1.fb_addr] : 6'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_row   = '0;
            rise_cnt  = 0;
            cyc_since = 0;
            oe_hi     = 0;
            dirty     = 1'b1;
            prev_clk  = 1'b0;
            prev_addr = '0;
         end else begin
            cyc_since++;
            if (bus.oe) oe_hi++;
            if (!enable) dirty = 1'b1;
            if (bus.clk_out && !prev_clk) begin
               chk("pixel", {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1},
                   mem[{exp_row, COL_W'(rise_cnt)}]);
               chk("r0_parity", bus.r0, rise_cnt[0]);
               rise_cnt++;
            end
            if (bus.addr != prev_addr) chk("addr_change_blanked", {bus.latch, bus.oe}, 2'b11);
            if (bus.frame_done) begin
               chk("frame_done_with_latch", bus.latch, 1);
               fd_cnt++;
            end
            if (bus.latch) begin
               chk("rises_per_row", rise_cnt, COLS);
               chk("latch_addr", bus.addr, exp_row);
               chk("frame_done_level", bus.frame_done, exp_row == ADDR_W'(ROWS - 1));
               if (!dirty) begin
                  chk("row_period", cyc_since, PERIOD);
                  chk("oe_high_cycles", oe_hi, 2);
               end
               exp_row   = exp_row + 1'b1;
               rise_cnt  = 0;
               cyc_since = 0;
               oe_hi     = 0;
               dirty     = 1'b0;
            end
            prev_clk  = bus.clk_out;
            prev_addr = bus.addr;
         end
      end
   endtask

   task automatic wait_latch();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.latch && n < 2000);
      chk("latch_seen", bus.latch, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int n, nlat, cyc, last, lo;
      rst_n  = 1'b0;
      enable = 1'b0;
      rst1_n = 1'b0;
      en1    = 1'b0;
      fd_cnt = 0;
      for (int i = 0; i < (1 << (ADDR_W + COL_W)); i++)
         mem[i] = {i[0], 5'($urandom)};
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("reset_oe", bus.oe, 1);
      chk("reset_outputs", {bus.latch, bus.clk_out, bus.fb_rd_en, bus.frame_done,
                            bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1}, 0);
      chk("reset_addrs", {bus.addr, bus.fb_addr}, 0);

      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_no_read", bus.fb_rd_en, 0);
      chk("idle_oe", bus.oe, 1);
      enable = 1'b1;
      @(negedge clk);
      chk("first_read", bus.fb_rd_en, 1);
      chk("first_read_addr", bus.fb_addr, 0);

      // one full frame plus the wrap back to row 0
      for (int i = 0; i <= ROWS; i++) wait_latch();
      chk("wrap_addr", bus.addr, 0);
      chk("frame_done_once", fd_cnt, 1);

      wait_latch();
      wait_latch();
      chk("pre_drop_addr", bus.addr, 2);
      repeat (OE_ON + 40) @(negedge clk);
      enable = 1'b0;
      wait_latch();
      chk("drop_latch_addr", bus.addr, 3);
      n = 0;
      @(negedge clk);
      while (!bus.oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk("drop_oe_low_cycles", n, OE_ON - 1);
      repeat (5) @(negedge clk);
      chk("parked_oe", bus.oe, 1);
      chk("parked_no_read", bus.fb_rd_en, 0);
      chk("parked_clk_out", bus.clk_out, 0);
      enable = 1'b1;
      wait_latch();
      chk("resume_row", bus.addr, 4);

      // async reset in the middle of a shift
      @(negedge clk);
      n = 0;
      while (rise_cnt < 20 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_col20", (rise_cnt >= 20), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_oe", bus.oe, 1);
      chk("arst_latch", bus.latch, 0);
      chk("arst_clk_out", bus.clk_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_latch();
      chk("post_reset_row", bus.addr, 0);

      // OE_ON=1 instance
      rst1_n = 1'b1;
      en1    = 1'b1;
      nlat = 0; cyc = 0; last = 0; lo = 0;
      while (nlat < 3 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (bus1.latch) begin
            if (nlat > 0) begin
               chk("short_period", cyc - last, 2 * COLS + 3);
               chk("short_oe_low", lo, 2 * COLS + 1);
            end
            chk("short_addr", bus1.addr, nlat);
            last = cyc;
            lo   = 0;
            nlat++;
         end else if (!bus1.oe) begin
            lo++;
         end
      end
      chk("short_latches", nlat, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
